// File: rtl/ram_requester_pkg.sv
// Shared constants for the RAM requester and the RAM it drives: word size,
// opcode fields and the requester state encoding.
package ram_requester_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int LEN_WIDTH  = 4;

    localparam logic [3:0] RAM_OP    = 4'h4;
    localparam logic [3:0] ROM_OP    = 4'h3;
    localparam logic [3:0] REG_OP    = 4'h9;
    localparam logic [3:0] RAM_WRITE = 4'h1;
    localparam logic [3:0] RAM_READ  = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } req_state_t;

endpackage

// File: rtl/ram_requester.sv
// Turns single-word write and burst read commands into RAM strobes and
// returns read words through a one-deep valid/ready response register.
//   state    | meaning
//   ST_IDLE  | accepting commands; a read response may still be pending
//   ST_WRITE | one-cycle write strobe to the latched address
//   ST_READ  | burst read, one word per cycle while the response slot is free
module ram_requester
    import ram_requester_pkg::*;
#(
    parameter int DATA_WIDTH = ram_requester_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_requester_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic [15:0]           ram_opcode,
    output logic [15:0]           ram_operand,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_read_enable,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_read_data
);

    req_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_last;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic w_issue_rd;
    logic w_issue_wr;

    // Strobes are gated by reset so the RAM sees nothing while reset is low,
    // even before the synchronous reset has returned the FSM to idle.
    assign w_issue_rd = reset && (r_state == ST_READ) && (!r_rsp_valid || rsp_ready);
    assign w_issue_wr = reset && (r_state == ST_WRITE);

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_last  = r_rsp_last;
    assign rsp_data  = r_rsp_data;

    always_comb begin
        ram_opcode       = 16'h0000;
        ram_operand      = 16'h0000;
        ram_write_data   = '0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        if (w_issue_wr) begin
            ram_opcode       = {ROM_OP, RAM_WRITE, 8'(r_addr)};
            ram_write_data   = r_wdata;
            ram_write_enable = 1'b1;
        end else if (w_issue_rd) begin
            ram_opcode      = {RAM_OP, RAM_READ, 8'h00};
            ram_operand     = 16'(r_addr);
            ram_read_enable = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_remaining <= cmd_len;
                        r_state     <= cmd_write ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end
                ST_READ: begin
                    // A capture here overrides the clear above on the same edge.
                    if (w_issue_rd) begin
                        r_rsp_data  <= ram_read_data;
                        r_rsp_valid <= 1'b1;
                        r_rsp_last  <= (r_remaining == '0);
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == '0) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_requester.sv
// Directed bench for ram_requester with a behavioural RAM and strobe monitor.
module tb_ram_requester;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic [15:0] ram_opcode;
    logic [15:0] ram_operand;
    logic [15:0] ram_write_data;
    logic        ram_read_enable;
    logic        ram_write_enable;
    logic [15:0] ram_read_data;

    int checks   = 0;
    int failures = 0;

    int cnt_we   = 0;
    int cnt_re   = 0;
    int cnt_b2b  = 0;
    int cnt_both = 0;
    logic prev_we = 1'b0;

    logic [15:0] mem [256];

    ram_requester dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_write        (cmd_write),
        .cmd_addr         (cmd_addr),
        .cmd_len          (cmd_len),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_last         (rsp_last),
        .busy             (busy),
        .ram_opcode       (ram_opcode),
        .ram_operand      (ram_operand),
        .ram_write_data   (ram_write_data),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_read_data    (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_enable) mem[ram_opcode[7:0]] <= ram_write_data;
    end
    assign ram_read_data = mem[ram_operand[7:0]];

    always @(posedge clk) begin
        if (ram_write_enable) cnt_we++;
        if (ram_read_enable) cnt_re++;
        if (ram_write_enable && prev_we) cnt_b2b++;
        if (ram_write_enable && ram_read_enable) cnt_both++;
        prev_we = ram_write_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at a falling edge with the FSM back in idle.
    task automatic do_write(input logic [7:0] a, input logic [15:0] d);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    int re_snap;
    int we_snap;
    int b2b_snap;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h00;
        cmd_len   = 4'h0;
        cmd_wdata = 16'h0000;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'h0);
        check("reset_ram_strobes", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        check("reset_ram_opcode", 32'(ram_opcode), 32'h0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

        // Write BEEF to 0x10, then read it back.
        we_snap   = cnt_we;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h10;
        cmd_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wr_we", 32'(ram_write_enable), 32'd1);
        check("wr_opcode", 32'(ram_opcode), 32'h3110);
        check("wr_data", 32'(ram_write_data), 32'hBEEF);
        check("wr_operand", 32'(ram_operand), 32'h0);
        check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("wr_done_ready", 32'(cmd_ready), 32'd1);
        check("wr_done_we", 32'(ram_write_enable), 32'd0);
        check("wr_pulse_count", 32'(cnt_we - we_snap), 32'd1);

        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h10;
        cmd_len   = 4'h0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rd1_re", 32'(ram_read_enable), 32'd1);
        check("rd1_opcode", 32'(ram_opcode), 32'h4200);
        check("rd1_operand", 32'(ram_operand), 32'h0010);
        check("rd1_rsp_valid_before", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rd1_rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'h3BEEF);
        check("rd1_idle_re", 32'(ram_read_enable), 32'd0);
        check("rd1_idle_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("rd1_consumed", 32'(rsp_valid), 32'd0);

        // Burst across the address wrap.
        do_write(8'hFE, 16'h0001);
        do_write(8'hFF, 16'h0002);
        do_write(8'h00, 16'h0003);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'hFE;
        cmd_len   = 4'h2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("wrap_op0", 32'(ram_operand), 32'h00FE);
        @(posedge clk);
        @(negedge clk);
        check("wrap_rsp0", 32'({rsp_valid, rsp_last, rsp_data}), 32'h20001);
        check("wrap_op1", 32'({ram_read_enable, ram_operand}), 32'h100FF);
        @(posedge clk);
        @(negedge clk);
        check("wrap_rsp1", 32'({rsp_valid, rsp_last, rsp_data}), 32'h20002);
        check("wrap_op2", 32'({ram_read_enable, ram_operand}), 32'h10000);
        @(posedge clk);
        @(negedge clk);
        check("wrap_rsp2", 32'({rsp_valid, rsp_last, rsp_data}), 32'h30003);
        check("wrap_idle_re", 32'(ram_read_enable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("wrap_consumed", 32'(rsp_valid), 32'd0);

        // Backpressure: consumer stalls for five cycles after the first word.
        do_write(8'h20, 16'h00A0);
        do_write(8'h21, 16'h00A1);
        do_write(8'h22, 16'h00A2);
        do_write(8'h23, 16'h00A3);
        rsp_ready = 1'b0;
        re_snap   = cnt_re;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        cmd_len   = 4'h3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("bp_first_re", 32'({ram_read_enable, ram_operand}), 32'h10020);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_rsp", 32'({rsp_valid, rsp_last, rsp_data}), 32'h200A0);
            check("bp_hold_re", 32'(ram_read_enable), 32'd0);
        end
        check("bp_strobe_count", 32'(cnt_re - re_snap), 32'd1);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_re", 32'({ram_read_enable, ram_operand}), 32'h10021);
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp1", 32'({rsp_valid, rsp_last, rsp_data}), 32'h200A1);
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp2", 32'({rsp_valid, rsp_last, rsp_data}), 32'h200A2);
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp3", 32'({rsp_valid, rsp_last, rsp_data}), 32'h300A3);
        check("bp_total_strobes", 32'(cnt_re - re_snap), 32'd4);
        @(posedge clk);
        @(negedge clk);
        check("bp_consumed", 32'(rsp_valid), 32'd0);

        // Reset during the second beat of a 16-word burst.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h40;
        cmd_len   = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_beat2_re", 32'({ram_read_enable, ram_operand}), 32'h10041);
        reset = 1'b0;
        #1;
        check("rst_mid_gated", 32'({ram_read_enable, ram_write_enable}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        re_snap = cnt_re;
        reset   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_mid_no_strobes", 32'(cnt_re - re_snap), 32'd0);
        check("rst_mid_rsp_after", 32'(rsp_valid), 32'd0);

        // Back-to-back writes with cmd_valid held.
        we_snap   = cnt_we;
        b2b_snap  = cnt_b2b;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h50;
        cmd_wdata = 16'h1234;
        repeat (8) @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_we_count", 32'(cnt_we - we_snap), 32'd4);
        check("b2b_consecutive", 32'(cnt_b2b - b2b_snap), 32'd0);
        check("b2b_mem", 32'(mem[8'h50]), 32'h1234);
        check("never_both_strobes", 32'(cnt_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
